seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the combinational datapath ALU.
- Single-cycle logic/arith/shift ops plus iterative WIDTH-cycle shift-add multiply and restoring divide, which return a full double-width product and a remainder.
- Sits between the decode/register-read stage and writeback behind a valid/ready handshake, so the pipeline can stall on long ops.
- Keeps the 4-bit op encoding and 8-bit status layout of the existing ALU.

Parameters:
- WIDTH, 32, operand/result width; must be >= 8 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived; not for override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  4  operation code, sampled on accept.
- operand_1  input  WIDTH  first operand.
- operand_2  input  WIDTH  second operand.
- shamt  input  SHW  shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  primary result (low product / quotient).
- result_hi  output  WIDTH  high product half, or remainder; 0 for other ops.
- status  output  8  {zero, overflow, carry, negative, invalid_address, div_zero, 2'b00}.

Behaviour:
- Reset (synchronous, active-high, on the clk edge):
  - state=IDLE, out_valid=0, result=0, result_hi=0, status=0, iteration counter=0.
  - Reset mid-operation abandons the op; no result is ever presented for it.
- States: IDLE, BUSY, DONE.
- Handshake:
  - in_ready=1 only in IDLE. Accept = in_valid & in_ready; op and operands are latched on accept.
  - out_valid=1 only in DONE. result, result_hi and status are held stable until out_valid & out_ready; then the block returns to IDLE.
  - No overlap between ops: the next accept happens at the earliest one cycle after the output handshake.
- Op codes:
  - 0000 and; 0001 or; 1100 nor.
  - 0010 add; 0110 sub.
  - 0111 slt, signed compare; 0101 sltu, unsigned compare. Both return 1 or 0.
  - 1110 sll; 1111 srl, logical shift of operand_1 by shamt.
  - 0011 mulu, unsigned.
  - 0100 divu, unsigned.
  - Any other code: result=0, status=0, completes as a single-cycle op.
- Latency:
  - Single-cycle ops: IDLE -> DONE on accept; out_valid the cycle after accept.
  - mulu/divu: IDLE -> BUSY, exactly WIDTH iterations, then DONE. out_valid occurs WIDTH+1 cycles after the accept edge.
- mulu:
  - {result_hi, result} = full 2*WIDTH product.
  - overflow = (result_hi != 0); carry = 0.
- divu:
  - result = quotient, result_hi = remainder (restoring algorithm, one bit per cycle).
  - Divide by zero skips BUSY and goes straight to DONE: result = all ones, result_hi = operand_1, div_zero = 1.
- Flags (computed on the final result):
  - zero = (result == 0); negative = result[WIDTH-1]; invalid_address = (result[1:0] != 0).
  - add: carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = same-sign operands with a differing-sign result.
  - sub: carry = borrow (operand_1 < operand_2, unsigned); overflow = differing-sign operands with result sign != operand_1 sign.
  - Logic, shift and compare ops: overflow = carry = 0.
  - div_zero = 1 only for a divide with operand_2 == 0.
- Input changes after accept have no effect on the op in flight.
- in_valid while not in IDLE is ignored, because in_ready = 0.

Optional Feature:
- Macro SEQ_ALU_SIGNED_MULDIV_EN.
- When defined, two extra ops are added:
  - 1000 muls: signed two's-complement product. overflow = (result_hi is not the sign-extension of result).
  - 1001 divs: signed divide, quotient truncates toward zero, remainder takes the sign of the dividend. The same WIDTH+1 latency applies.
  - Most-negative / -1 gives quotient = most-negative, remainder = 0, overflow = 1.
  - Divide by zero behaves as for divu.
- When not defined, 1000 and 1001 decode as unsupported: result = 0, status = 0, single-cycle completion.

Test Plan:
- Reset and add overflow: assert reset for 2 cycles mid-mulu -> out_valid=0, in_ready=1 next cycle. Then add 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, carry=0, negative=1, out_valid 1 cycle after accept.
- Sub borrow: sub 0x00000001-0x00000002 -> result 0xFFFFFFFF, carry=1, overflow=0. slt 0xFFFFFFFF,1 -> 1; sltu same operands -> 0.
- Multiply: mulu 0xFFFFFFFF*0xFFFFFFFF -> result 0x00000001, result_hi 0xFFFFFFFE, overflow=1. out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- Divide and divide by zero: divu 100/7 -> result 14, result_hi 2. divu 5/0 -> result 0xFFFFFFFF, result_hi 5, div_zero=1, out_valid 1 cycle after accept.
- Back-pressure: hold out_ready=0 for 10 cycles after sll 0x1 by 31 -> result 0x80000000 stable, in_valid pulses ignored. On release, the next request is accepted the following cycle.
- With SEQ_ALU_SIGNED_MULDIV_EN: divs -7/2 -> result 0xFFFFFFFD, result_hi 0xFFFFFFFF. Without the macro, op 1001 -> result 0, status 0.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic/arith/shift ops plus iterative mul/div.
// Optional signed muls/divs ops are enabled by defining SEQ_ALU_SIGNED_MULDIV_EN.
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       status
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MULU = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULS = 4'b1000;
  localparam logic [3:0] OP_DIVS = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1110;
  localparam logic [3:0] OP_SRL  = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;

  logic             accept, is_signed_in, is_mul_in, is_div_in, is_long_in, div_zero_in;
  logic [WIDTH-1:0] mag_1, mag_2;
  logic             is_div_q, signed_q, sign_1_q, sign_2_q;
  logic [WIDTH-1:0] divisor_q, hi_q, lo_q, hi_nx, lo_nx;
  logic [SHW-1:0]   count;
  logic             last_iter;
  logic [WIDTH:0]   sum, diff, mul_sum, trial;
  logic [WIDTH-1:0] sc_result;
  logic             sc_ov, sc_cy, sc_valid;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fin_result, fin_hi;
  logic             fin_ov;

  function automatic logic [7:0] flags(input logic [WIDTH-1:0] r, input logic ov, input logic cy,
                                       input logic dz);
    return {r == '0, ov, cy, r[WIDTH-1], r[1:0] != 2'b00, dz, 2'b00};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

`ifdef SEQ_ALU_SIGNED_MULDIV_EN
  assign is_signed_in = (op == OP_MULS) || (op == OP_DIVS);
`else
  assign is_signed_in = 1'b0;
`endif
  assign is_mul_in   = (op == OP_MULU) || (is_signed_in && op == OP_MULS);
  assign is_div_in   = (op == OP_DIVU) || (is_signed_in && op == OP_DIVS);
  assign is_long_in  = is_mul_in | is_div_in;
  assign div_zero_in = is_div_in && (operand_2 == '0);
  // Signed ops iterate on magnitudes; signs are reapplied when the last step completes
  assign mag_1 = (is_signed_in && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
  assign mag_2 = (is_signed_in && operand_2[WIDTH-1]) ? -operand_2 : operand_2;
  assign last_iter = (count == '1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (is_long_in && !div_zero_in) ? BUSY : DONE;
      BUSY: if (last_iter) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sum       = {1'b0, operand_1} + {1'b0, operand_2};
    diff      = {1'b0, operand_1} - {1'b0, operand_2};
    sc_result = '0;
    sc_ov     = 1'b0;
    sc_cy     = 1'b0;
    sc_valid  = 1'b1;
    case (op)
      OP_AND:  sc_result = operand_1 & operand_2;
      OP_OR:   sc_result = operand_1 | operand_2;
      OP_NOR:  sc_result = ~(operand_1 | operand_2);
      OP_ADD: begin
        sc_result = sum[WIDTH-1:0];
        sc_cy     = sum[WIDTH];
        sc_ov     = (operand_1[WIDTH-1] == operand_2[WIDTH-1]) && (sum[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff[WIDTH-1:0];
        sc_cy     = diff[WIDTH];
        sc_ov     = (operand_1[WIDTH-1] != operand_2[WIDTH-1]) && (diff[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(operand_1) < $signed(operand_2)};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, operand_1 < operand_2};
      OP_SLL:  sc_result = operand_1 << shamt;
      OP_SRL:  sc_result = operand_1 >> shamt;
      default: sc_valid = 1'b0;
    endcase
  end

  // One shift-add or restoring-divide step, plus the signed fix-up of the step's outcome
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, divisor_q} : '0);
    trial   = {hi_q, lo_q[WIDTH-1]} - {1'b0, divisor_q};
    if (is_div_q) begin
      if (!trial[WIDTH]) begin
        hi_nx = trial[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_nx, lo_nx} = {mul_sum, lo_q[WIDTH-1:1]};
    end
    prod = {hi_nx, lo_nx};
    if (is_div_q) begin
      fin_result = (signed_q && (sign_1_q ^ sign_2_q)) ? -lo_nx : lo_nx;
      fin_hi     = (signed_q && sign_1_q) ? -hi_nx : hi_nx;
      fin_ov     = signed_q && !(sign_1_q ^ sign_2_q) && lo_nx[WIDTH-1];
    end else begin
      if (signed_q && (sign_1_q ^ sign_2_q)) prod = -prod;
      fin_result = prod[WIDTH-1:0];
      fin_hi     = prod[2*WIDTH-1:WIDTH];
      fin_ov     = signed_q ? (fin_hi != {WIDTH{fin_result[WIDTH-1]}}) : (fin_hi != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      result_hi <= '0;
      status    <= '0;
      count     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divisor_q <= '0;
      is_div_q  <= 1'b0;
      signed_q  <= 1'b0;
      sign_1_q  <= 1'b0;
      sign_2_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          is_div_q  <= is_div_in;
          signed_q  <= is_signed_in;
          sign_1_q  <= operand_1[WIDTH-1];
          sign_2_q  <= operand_2[WIDTH-1];
          divisor_q <= mag_2;
          lo_q      <= mag_1;
          hi_q      <= '0;
          count     <= '0;
          if (div_zero_in) begin
            result    <= {WIDTH{1'b1}};
            result_hi <= operand_1;
            status    <= flags({WIDTH{1'b1}}, 1'b0, 1'b0, 1'b1);
          end else if (!is_long_in) begin
            result    <= sc_result;
            result_hi <= '0;
            status    <= sc_valid ? flags(sc_result, sc_ov, sc_cy, 1'b0) : 8'h00;
          end
        end
        BUSY: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          count <= count + 1'b1;
          if (last_iter) begin
            result    <= fin_result;
            result_hi <= fin_hi;
            status    <= flags(fin_result, fin_ov, 1'b0, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
